load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's MEM stage and the data memory. Accepts one load/store per
//  handshake, decodes RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW) and builds the memory
//  signals: word-aligned address, we, byte-lane mask and lane-shifted store data.
//  Load data is aligned, sign/zero-extended and returned with done_o.
// PARAMETERS
//  ADDR_WIDTH      `MEM_ADDR_WIDTH  byte-address width on both sides
//  DATA_WIDTH      32               fixed; other values unsupported
//  TRANSFER_WIDTH  4                byte-lane mask width (DATA_WIDTH/8)
// PORTS
//  clk             in   1               clock, rising edge
//  rst_n           in   1               asynchronous, active-low reset
//  req_i           in   1               request valid; accepted only when ready_o=1
//  store_i         in   1               1=store, 0=load
//  funct3_i        in   3               RV32I width/sign code
//  addr_i          in   ADDR_WIDTH      byte address
//  wdata_i         in   32              store data, LSB-justified
//  ready_o         out  1               1 iff FSM in IDLE
//  done_o          out  1               one-cycle completion pulse
//  err_o           out  1               valid with done_o: illegal funct3 or unsupported misalign
//  rdata_o         out  32              extended load data; held until next accepted req
//  mem_addr_o      out  ADDR_WIDTH      word-aligned address (low 2 bits always 0)
//  mem_we_o        out  1               memory write enable
//  mem_data_o      out  32              lane-shifted store data
//  mem_transfer_o  out  TRANSFER_WIDTH  byte-lane mask
//  mem_data_i      in   32              combinational read word (valid when mem_we_o=0)
// BEHAVIOUR
//  Reset: state=IDLE, ready_o=1; done_o, err_o, mem_we_o=0; rdata_o, mem_addr_o,
//   mem_data_o, mem_transfer_o=0; takes effect immediately, mid-access included.
//  FSM: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE.
//   IDLE: req_i=1 latches store_i/funct3_i/addr_i/wdata_i. Illegal (load 011/110/111,
//    store other than 000/001/010) -> RESP with err=1, no memory access.
//   ACC0: mem_addr_o={addr[AW-1:2],2'b00}; off=addr[1:0]; base mask B=0001/0011/1111
//    (byte/half/word); M=B<<off (8 bits); S={32'b0,wdata}<<(8*off) (64 bits).
//    Drives mem_transfer_o=M[3:0], mem_data_o=S[31:0], mem_we_o=store; loads capture
//    mem_data_i into LO. Next ACC1 if M[7:4]!=0, else RESP.
//   ACC1: mem_addr_o = ACC0 address + 4 (wraps modulo 2^ADDR_WIDTH);
//    mem_transfer_o=M[7:4], mem_data_o=S[63:32]; loads capture HI. Next RESP.
//   RESP: done_o=1 one cycle; loads set rdata_o=ext(({HI,LO}>>(8*off))) (HI=0 when
//    no ACC1): LB/LH sign-extend bit 7/15, LBU/LHU zero-extend. Stores and errors
//    leave rdata_o unchanged. Next IDLE.
//  Outside ACC0/ACC1: mem_we_o=0, mem_transfer_o=0, mem_addr_o=0.
//  mem_transfer_o is never 0 while mem_we_o=1 (memory treats a 0 mask as a full-word write).
//  Latency (req accepted at edge N): aligned done_o in cycle N+2; split N+3; error N+1.
//  req_i while ready_o=0 is ignored, not queued. Back-to-back: new req accepted in
//   the cycle after RESP.
//  err_o is 0 whenever done_o=0.
// CONFIGURATION
//  LSU_MISALIGNED_SPLIT_EN defined: accesses with M[7:4]!=0 (LH off=3, LW off!=0)
//   split into ACC0+ACC1 as above.
//  Undefined: such accesses go IDLE->RESP with err_o=1, no memory access, latency N+1;
//   ACC1 state not built.
// TESTING
//  1 SW 0xDEADBEEF @0x10 -> ACC0 mask 1111, data 0xDEADBEEF; then LW @0x10 ->
//    rdata_o=0xDEADBEEF, done_o in cycle N+2, err_o=0.
//  2 SB 0x000000A5 @0x13 -> mask 1000, mem_data_o=0xA5000000; LB @0x13 ->
//    0xFFFFFFA5; LBU @0x13 -> 0x000000A5; other bytes of word 0x10 unchanged.
//  3 SH 0x00008001 @0x22 -> mask 1100; LH -> 0xFFFF8001; LHU -> 0x00008001.
//  4 Preload word0x10=0x44332211, word0x14=0x88776655; LW @0x11: with EN ->
//    addrs 0x10,0x14, rdata_o=0x55443322 at N+3; without EN -> err_o=1 at N+1,
//    mem_we_o never 1, rdata_o unchanged.
//  5 Load funct3=011 -> err_o=1 at N+1, no access. req_i held high during ACC0 ->
//    only one access. rst_n low during ACC1 of split SW -> mem_we_o=0 same cycle,
//    word 0x14 unchanged, ready_o=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes funct3, drives byte-lane masked word accesses and extends load data.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses in two; MEM_ADDR_WIDTH sets the address width.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module load_store_unit #(
    parameter int ADDR_WIDTH     = `MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic                      store_i,
    input  logic [2:0]                funct3_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_data_o,
    output logic [TRANSFER_WIDTH-1:0] mem_transfer_o,
    input  logic [DATA_WIDTH-1:0]     mem_data_i
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam int SPAN = 2 * DATA_WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd2, ACC1 = 2'd3} state_t;
`else
    localparam int SPAN = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd2} state_t;
`endif
    localparam int MSPAN = SPAN / 8;

    state_t state, next_state;

    logic                  store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [MSPAN-1:0]      mask_q;
    logic [SPAN-1:0]       data_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [DATA_WIDTH-1:0] lo_q;
`endif

    logic [7:0]            in_mask;
    logic [SPAN-1:0]       in_data;
    logic                  in_err;
    logic [ADDR_WIDTH-1:0] word_addr;

    function automatic logic is_legal(input logic st, input logic [2:0] f3);
        if (st) return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] base;
        case (f3[1:0])
            2'b00:   base = 8'b0000_0001;
            2'b01:   base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    // Pair holds {upper word, lower word}; the addressed bytes are shifted down to bit 0.
    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        in_mask = lane_mask(funct3_i, addr_i[1:0]);
        in_data = SPAN'(wdata_i) << {addr_i[1:0], 3'b000};
`ifdef LSU_MISALIGNED_SPLIT_EN
        in_err  = !is_legal(store_i, funct3_i);
`else
        in_err  = !is_legal(store_i, funct3_i) || (|in_mask[7:4]);
`endif
    end

    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign rdata_o   = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state     = state;
        ready_o        = 1'b0;
        done_o         = 1'b0;
        err_o          = 1'b0;
        mem_addr_o     = '0;
        mem_we_o       = 1'b0;
        mem_data_o     = '0;
        mem_transfer_o = '0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (req_i) next_state = in_err ? RESP : ACC0;
            end
            ACC0: begin
                mem_addr_o     = word_addr;
                mem_we_o       = store_q;
                mem_transfer_o = mask_q[3:0];
                mem_data_o     = data_q[31:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                next_state     = (|mask_q[7:4]) ? ACC1 : RESP;
            end
            ACC1: begin
                mem_addr_o     = word_addr + ADDR_WIDTH'(4);
                mem_we_o       = store_q;
                mem_transfer_o = mask_q[7:4];
                mem_data_o     = data_q[63:32];
                next_state     = RESP;
`else
                next_state     = RESP;
`endif
            end
            RESP: begin
                done_o     = 1'b1;
                err_o      = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture and load-data return; rdata only moves when a load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            lo_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        store_q  <= store_i;
                        funct3_q <= funct3_i;
                        addr_q   <= addr_i;
                        mask_q   <= in_mask[MSPAN-1:0];
                        data_q   <= in_data;
                        err_q    <= in_err;
                    end
                end
                ACC0: begin
                    if (!store_q) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        lo_q <= mem_data_i;
                        if (!(|mask_q[7:4]))
                            rdata_q <= extend({32'b0, mem_data_i}, funct3_q, addr_q[1:0]);
`else
                        rdata_q <= extend({32'b0, mem_data_i}, funct3_q, addr_q[1:0]);
`endif
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                ACC1: begin
                    if (!store_q)
                        rdata_q <= extend({mem_data_i, lo_q}, funct3_q, addr_q[1:0]);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expectations, a negedge monitor checks them.
module tb_load_store_unit;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nacc;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [3:0]  mask0;
        logic [31:0] data0;
        logic        we;
        int          acc_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mem_we;
    logic [31:0] rdata, mem_addr, mem_data_out, mem_data_in;
    logic [3:0]  mem_transfer;

    logic [31:0] mem [0:63];
    logic        mem_clr = 1'b1;
    logic        pl_go = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   txn = 0;

    int          n_seen = 0;
    logic [31:0] cap_addr0 = '0, cap_addr1 = '0, cap_data0 = '0;
    logic [3:0]  cap_mask0 = '0;
    logic        cap_we = 1'b0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .store_i        (store),
        .funct3_i       (funct3),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .ready_o        (ready),
        .done_o         (done),
        .err_o          (err),
        .rdata_o        (rdata),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_data_o     (mem_data_out),
        .mem_transfer_o (mem_transfer),
        .mem_data_i     (mem_data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_data_in = mem[mem_addr[7:2]];

    // Byte-lane memory model, plus bench-side clear and preload ports.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (pl_go) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_transfer[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_data_out[8*b +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic e, input logic [31:0] rd, input int lat,
                                input int nacc, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [3:0] m0, input logic [31:0] d0, input logic we);
        exp_t x;
        x.id = 0; x.err = e; x.rdata = rd; x.lat = lat; x.nacc = nacc;
        x.addr0 = a0; x.addr1 = a1; x.mask0 = m0; x.data0 = d0; x.we = we; x.acc_edge = 0;
        return x;
    endfunction

    // Monitor: records memory accesses of the current transaction, checks on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_seen = 0;
            cap_we = 1'b0;
        end else begin
            if (mem_transfer != 4'b0 || mem_we) begin
                n_seen++;
                if (n_seen == 1) begin
                    cap_addr0 = mem_addr;
                    cap_mask0 = mem_transfer;
                    cap_data0 = mem_data_out;
                end else begin
                    cap_addr1 = mem_addr;
                end
                if (mem_we) begin
                    cap_we = 1'b1;
                    checkOutput("we_mask_nonzero", {31'b0, mem_transfer != 4'b0}, 32'd1);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_done: got done=%0b expected no completion", done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput($sformatf("txn%0d_err", e.id), {31'b0, err}, {31'b0, e.err});
                    checkOutput($sformatf("txn%0d_rdata", e.id), rdata, e.rdata);
                    checkOutput($sformatf("txn%0d_latency", e.id), cyc - e.acc_edge + 1, e.lat);
                    checkOutput($sformatf("txn%0d_accesses", e.id), n_seen, e.nacc);
                    checkOutput($sformatf("txn%0d_we", e.id), {31'b0, cap_we}, {31'b0, e.we});
                    if (e.nacc > 0) begin
                        checkOutput($sformatf("txn%0d_addr0", e.id), cap_addr0, e.addr0);
                        checkOutput($sformatf("txn%0d_mask0", e.id), {28'b0, cap_mask0}, {28'b0, e.mask0});
                        checkOutput($sformatf("txn%0d_data0", e.id), cap_data0, e.data0);
                    end
                    if (e.nacc == 2)
                        checkOutput($sformatf("txn%0d_addr1", e.id), cap_addr1, e.addr1);
                end
                n_seen = 0;
                cap_we = 1'b0;
            end else begin
                checkOutput("err_without_done", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic waitDone();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int hold, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: got ready=%0b expected 1", ready);
            return;
        end
        txn++;
        e.id = txn;
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        store = st; funct3 = f3; addr = a; wdata = wd; req = 1'b1;
        repeat (hold + 1) @(posedge clk);
        #1 req = 1'b0;
        waitDone();
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_idx = idx; pl_val = val; pl_go = 1'b1;
        @(posedge clk);
        #1 pl_go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] last;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_data", mem_data_out, 32'd0);
        checkOutput("rst_transfer", {28'b0, mem_transfer}, 32'd0);
        rst_n = 1'b1;
        mem_clr = 1'b0;

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0,
                      mk(1'b0, 32'h0, 2, 1, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1));
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0,
                      mk(1'b0, 32'hDEADBEEF, 2, 1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0));
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h000000A5, 0,
                      mk(1'b0, 32'hDEADBEEF, 2, 1, 32'h10, 32'h0, 4'h8, 32'hA5000000, 1'b1));
        checkOutput("mem_w10_after_sb", mem[4], 32'hA5ADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 0,
                      mk(1'b0, 32'hFFFFFFA5, 2, 1, 32'h10, 32'h0, 4'h8, 32'h0, 1'b0));
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 0,
                      mk(1'b0, 32'h000000A5, 2, 1, 32'h10, 32'h0, 4'h8, 32'h0, 1'b0));
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h00008001, 0,
                      mk(1'b0, 32'h000000A5, 2, 1, 32'h20, 32'h0, 4'hC, 32'h80010000, 1'b1));
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 0,
                      mk(1'b0, 32'hFFFF8001, 2, 1, 32'h20, 32'h0, 4'hC, 32'h0, 1'b0));
        applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, 0,
                      mk(1'b0, 32'h00008001, 2, 1, 32'h20, 32'h0, 4'hC, 32'h0, 1'b0));

        preload(6'd4, 32'h44332211);
        preload(6'd5, 32'h88776655);
`ifdef LSU_MISALIGNED_SPLIT_EN
        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 0,
                      mk(1'b0, 32'h55443322, 3, 2, 32'h10, 32'h14, 4'hE, 32'h0, 1'b0));
        applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, 0,
                      mk(1'b0, 32'h00005544, 3, 2, 32'h10, 32'h14, 4'h8, 32'h0, 1'b0));
        last = 32'h00005544;
`else
        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, 0,
                      mk(1'b1, 32'h00008001, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0));
        applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, 0,
                      mk(1'b1, 32'h00008001, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0));
        last = 32'h00008001;
`endif
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 0,
                      mk(1'b1, last, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0));
        applyStimulus(1'b1, 3'b100, 32'h10, 32'h12345678, 0,
                      mk(1'b1, last, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0));
        checkOutput("mem_w10_after_bad_store", mem[4], 32'h44332211);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1,
                      mk(1'b0, 32'h44332211, 2, 1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0));

        // Reset in the middle of a store; the second word must never be written.
        @(negedge clk);
        store = 1'b1; funct3 = 3'b010; wdata = 32'hCAFEBABE; req = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
        addr = 32'h11;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1;
`else
        addr = 32'h14;
        @(posedge clk);
        #1 req = 1'b0;
`endif
        checkOutput("rst_mid_addr", mem_addr, 32'h14);
        checkOutput("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we_after", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mid_transfer", {28'b0, mem_transfer}, 32'd0);
        checkOutput("rst_mid_ready", {31'b0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_rel_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_rel_rdata", rdata, 32'd0);
        checkOutput("rst_rel_w14", mem[5], 32'h88776655);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checkOutput("rst_rel_w10", mem[4], 32'hFEBABE11);
`endif
        applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 0,
                      mk(1'b0, 32'h88776655, 2, 1, 32'h14, 32'h0, 4'hF, 32'h0, 1'b0));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
